// File: rtl/muldiv_iter_if.sv
// Request/result bundle between the EX stage and the iterative mul/div unit.
// The requester drives start/annul/op/operands; the unit returns busy, a ready pulse and the result.
// The master modport is the requester side and the slave modport is the arithmetic unit side.
interface muldiv_iter_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic               annul_i;
  logic [1:0]         op_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               busy_o;
  logic               ready_o;
  logic [2*WIDTH-1:0] result_o;
  logic               div_by_zero_o;

  modport master (
    output start_i, annul_i, op_i, opdata1_i, opdata2_i,
    input  busy_o, ready_o, result_o, div_by_zero_o
  );

  modport slave (
    input  start_i, annul_i, op_i, opdata1_i, opdata2_i,
    output busy_o, ready_o, result_o, div_by_zero_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Radix-2 iterative MULT/MULTU/DIV/DIVU unit producing {hi,lo} / {remainder,quotient}.
// Latency: ready pulses WIDTH+1 cycles after start is accepted (2 cycles for divide-by-zero).
// No backpressure: start is only taken in IDLE; annul aborts CALC/DIVZ; the result is held until the next completion.
module muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  muldiv_iter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIVZ, CALC, DONE} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               is_mul;
  logic               neg_q;     // quotient / whole product gets negated
  logic               neg_r;     // remainder gets negated (divide only)
  logic [WIDTH-1:0]   rem;       // div: partial remainder; mul: high accumulator half
  logic [WIDTH-1:0]   quo;       // div: dividend shifting out, quotient shifting in; mul: multiplier / low half
  logic [WIDTH-1:0]   mag2;      // divisor or multiplicand magnitude
  logic               busy;
  logic               ready;
  logic               dbz;
  logic [2*WIDTH-1:0] result;

  logic               sign1;
  logic               sign2;
  logic [WIDTH-1:0]   abs1;
  logic [WIDTH-1:0]   abs2;
  logic [WIDTH:0]     shifted;
  logic [WIDTH-1:0]   diff;
  logic               ge;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_nxt;
  logic [2*WIDTH-1:0] raw;
  logic [2*WIDTH-1:0] fin;

  // Operand magnitudes and the next iteration step for both algorithms, plus the sign-corrected final value.
  always_comb begin
    sign1   = bus.op_i[0] & bus.opdata1_i[WIDTH-1];
    sign2   = bus.op_i[0] & bus.opdata2_i[WIDTH-1];
    // The most-negative operand negates to itself, which read unsigned is exactly its magnitude.
    abs1    = sign1 ? -bus.opdata1_i : bus.opdata1_i;
    abs2    = sign2 ? -bus.opdata2_i : bus.opdata2_i;
    // Restoring divide: bring in the next dividend bit, subtract the divisor if it fits.
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, mag2});
    diff    = shifted[WIDTH-1:0] - mag2;
    // Shift-add multiply: add the multiplicand when the multiplier LSB is set, then shift right.
    sum     = {1'b0, rem} + (quo[0] ? {1'b0, mag2} : {(WIDTH+1){1'b0}});
    if (is_mul) begin
      rem_nxt = sum[WIDTH:1];
      quo_nxt = {sum[0], quo[WIDTH-1:1]};
    end else begin
      rem_nxt = ge ? diff : shifted[WIDTH-1:0];
      quo_nxt = {quo[WIDTH-2:0], ge};
    end
    // Both algorithms leave the result as {rem, quo}: {hi, lo} or {remainder, quotient}.
    raw = {rem_nxt, quo_nxt};
    fin = raw;
    if (is_mul) begin
      if (neg_q) fin = -raw;
    end else begin
      fin[WIDTH-1:0]       = neg_q ? -raw[WIDTH-1:0] : raw[WIDTH-1:0];
      fin[2*WIDTH-1:WIDTH] = neg_r ? -raw[2*WIDTH-1:WIDTH] : raw[2*WIDTH-1:WIDTH];
    end
  end

  // Control FSM with registered handshake outputs and the iteration datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_mul <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      rem    <= '0;
      quo    <= '0;
      mag2   <= '0;
      busy   <= 1'b0;
      ready  <= 1'b0;
      dbz    <= 1'b0;
      result <= '0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          busy  <= 1'b0;
          if (bus.start_i && !bus.annul_i) begin
            is_mul <= bus.op_i[1];
            neg_q  <= sign1 ^ sign2;
            neg_r  <= sign1;
            rem    <= '0;
            quo    <= abs1;
            mag2   <= abs2;
            cnt    <= '0;
            if (!bus.op_i[1] && (bus.opdata2_i == '0)) begin
              state <= DIVZ;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end
        end
        DIVZ: begin
          if (bus.annul_i) begin
            state <= IDLE;
          end else begin
            state  <= DONE;
            busy   <= 1'b1;
            ready  <= 1'b1;
            dbz    <= 1'b1;
            result <= '0;
          end
        end
        CALC: begin
          if (bus.annul_i) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            cnt <= cnt + 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
              state  <= DONE;
              ready  <= 1'b1;
              dbz    <= 1'b0;
              result <= fin;
            end
          end
        end
        DONE: begin
          // Result is already committed here, so annul has no effect.
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy_o        = busy;
  assign bus.ready_o       = ready;
  assign bus.div_by_zero_o = dbz;
  assign bus.result_o      = result;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: a 32-bit and an 8-bit instance against a plain-arithmetic reference model.
// Every cycle the compare block checks ready/busy/result/div_by_zero of both units against expectations.
// Directed cases pin the literal results; randomized operands and annul points cover the rest.
module tb_muldiv_iter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_iter_if #(.WIDTH(32)) b32 ();
  muldiv_iter_if #(.WIDTH(8))  b8 ();

  muldiv_iter #(.WIDTH(32), .CNT_W(6)) dut32 (.clk(clk), .rst(rst), .bus(b32.slave));
  muldiv_iter #(.WIDTH(8),  .CNT_W(4)) dut8  (.clk(clk), .rst(rst), .bus(b8.slave));

  // One expected operation: busy window, ready cycle (-1: never) and committed values.
  typedef struct {
    int          u;
    int          from;
    int          to;
    int          rdy;
    logic [63:0] res;
    logic        dbz;
  } rec_t;

  rec_t        q[$];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  bit          mon_en = 1'b0;
  int          rst_cyc = -1;
  logic [63:0] held_res [2];
  logic        held_dbz [2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: signed/unsigned integer arithmetic on w-bit operands; C-style truncating division.
  function automatic void model(input int w, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, output logic [63:0] r, output logic dbz);
    logic [63:0] m1, m2, ua, ub, uq, ur, up;
    longint      sa, sb, sq, sr, sp;
    m1 = (64'h1 << w) - 64'h1;
    m2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'h1 << (2 * w)) - 64'h1);
    ua = {32'h0, a} & m1;
    ub = {32'h0, b} & m1;
    sa = longint'(ua) - ((op[0] && ua[w-1]) ? (longint'(1) << w) : longint'(0));
    sb = longint'(ub) - ((op[0] && ub[w-1]) ? (longint'(1) << w) : longint'(0));
    dbz = 1'b0;
    r   = 64'h0;
    if (!op[1]) begin
      if (ub == 64'h0) begin
        dbz = 1'b1;
      end else if (op[0]) begin
        sq = sa / sb;
        sr = sa % sb;
        r  = ((64'(sr) & m1) << w) | (64'(sq) & m1);
      end else begin
        uq = ua / ub;
        ur = ua % ub;
        r  = ((ur & m1) << w) | (uq & m1);
      end
    end else if (op[0]) begin
      sp = sa * sb;
      r  = 64'(sp) & m2;
    end else begin
      up = ua * ub;
      r  = up & m2;
    end
  endfunction

  task automatic drive(input int u, input logic s, input logic an, input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (u == 0) begin
      b32.start_i = s; b32.annul_i = an; b32.op_i = op; b32.opdata1_i = a; b32.opdata2_i = b;
    end else begin
      b8.start_i = s; b8.annul_i = an; b8.op_i = op; b8.opdata1_i = a[7:0]; b8.opdata2_i = b[7:0];
    end
  endtask

  // Issue one operation on unit u (0: 32-bit, 1: 8-bit); ab = cycle (relative to accept) to pulse annul, -1 none.
  task automatic do_op(input int u, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int ab, output logic [63:0] res);
    int          w, c0, rel, k;
    rec_t        r;
    logic [63:0] er;
    logic        ed;
    w  = (u == 0) ? 32 : 8;
    model(w, op, a, b, er, ed);
    c0  = cyc;
    rel = ed ? 2 : w + 1;
    r.u = u; r.from = c0 + (ed ? 2 : 1); r.to = c0 + rel; r.rdy = c0 + rel; r.res = er; r.dbz = ed;
    if (ab >= 0 && ab < rel) begin
      r.to  = c0 + ab;
      r.rdy = -1;
    end
    q.push_back(r);
    drive(u, 1'b1, (ab == 0), op, a, b);
    for (k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      drive(u, 1'b0, 1'b0, op, a, b);
      if (q.size() == 0) break;
      drive(u, 1'b0, (cyc - c0 == ab), op, a, b);
    end
    chk("op_complete", 64'(q.size()), 64'h0);
    q.delete();
    drive(u, 1'b0, 1'b0, op, a, b);
    res = (u == 0) ? b32.result_o : {48'h0, b8.result_o};
  endtask

  function automatic logic [31:0] pick(input int w);
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_00FF;
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h1;
      2:       return m;
      3:       return 32'h1 << (w - 1);
      4:       return 32'($urandom_range(1, 15));
      default: return $urandom & m;
    endcase
  endfunction

  // Per-cycle compare of both units against the expectation queue and the held results.
  always @(negedge clk) begin : cmp
    logic [63:0] d_res [2];
    logic        d_rdy [2];
    logic        d_busy [2];
    logic        d_dbz [2];
    logic        has, e_rdy, e_busy;
    if (mon_en) begin
      if (cyc == rst_cyc) begin
        held_res[0] = 64'h0; held_res[1] = 64'h0;
        held_dbz[0] = 1'b0;  held_dbz[1] = 1'b0;
      end
      d_res[0] = b32.result_o;         d_res[1] = {48'h0, b8.result_o};
      d_rdy[0] = b32.ready_o;          d_rdy[1] = b8.ready_o;
      d_busy[0] = b32.busy_o;          d_busy[1] = b8.busy_o;
      d_dbz[0] = b32.div_by_zero_o;    d_dbz[1] = b8.div_by_zero_o;
      for (int u = 0; u < 2; u++) begin
        has    = (q.size() > 0) && (q[0].u == u);
        e_rdy  = has && (q[0].rdy == cyc);
        e_busy = has && (cyc >= q[0].from) && (cyc <= q[0].to);
        if (e_rdy) begin
          held_res[u] = q[0].res;
          held_dbz[u] = q[0].dbz;
        end
        chk($sformatf("ready_u%0d", u), 64'(d_rdy[u]), 64'(e_rdy));
        chk($sformatf("busy_u%0d", u), 64'(d_busy[u]), 64'(e_busy));
        chk($sformatf("result_u%0d", u), d_res[u], held_res[u]);
        chk($sformatf("dbz_u%0d", u), 64'(d_dbz[u]), 64'(held_dbz[u]));
      end
      if (q.size() > 0 && cyc >= q[0].to) void'(q.pop_front());
    end
  end

  initial begin : stim
    logic [63:0] res, er;
    logic        ed;
    int          c0, u, w, ab;
    logic [1:0]  op;
    logic [31:0] a, b;
    rec_t        r;

    held_res[0] = 64'h0; held_res[1] = 64'h0;
    held_dbz[0] = 1'b0;  held_dbz[1] = 1'b0;
    rst = 1'b1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_busy", 64'(b32.busy_o), 64'h0);
    chk("reset_ready", 64'(b32.ready_o), 64'h0);
    chk("reset_result", b32.result_o, 64'h0);
    chk("reset_dbz", 64'(b8.div_by_zero_o), 64'h0);
    mon_en = 1'b1;

    // Pin the reference model to hand-computed values.
    model(32, 2'b00, 32'd100, 32'd7, er, ed);          chk("model_divu", er, 64'h00000002_0000000E);
    model(32, 2'b01, 32'hFFFFFFF9, 32'h2, er, ed);     chk("model_div_neg", er, 64'hFFFFFFFF_FFFFFFFD);
    model(32, 2'b11, 32'h80000000, 32'h80000000, er, ed); chk("model_mult_mn", er, 64'h40000000_00000000);
    model(8, 2'b01, 32'h81, 32'h3, er, ed);            chk("model_div8", er, 64'h0000_0000_0000_FFD6);

    do_op(0, 2'b00, 32'd100, 32'd7, -1, res);          chk("divu_100_7", res, 64'h00000002_0000000E);
    do_op(0, 2'b01, 32'hFFFFFFF9, 32'h2, -1, res);     chk("div_m7_2", res, 64'hFFFFFFFF_FFFFFFFD);
    do_op(0, 2'b01, 32'h80000000, 32'hFFFFFFFF, -1, res); chk("div_mn_m1", res, 64'h00000000_80000000);
    do_op(0, 2'b01, 32'd5, 32'd0, -1, res);            chk("div_5_0", res, 64'h0);
    chk("div_5_0_flag", 64'(b32.div_by_zero_o), 64'h1);
    do_op(0, 2'b00, 32'd9, 32'd3, -1, res);            chk("divu_9_3", res, 64'h00000000_00000003);
    chk("divu_9_3_flag", 64'(b32.div_by_zero_o), 64'h0);
    do_op(0, 2'b11, 32'hFFFFFFFF, 32'h2, -1, res);     chk("mult_m1_2", res, 64'hFFFFFFFF_FFFFFFFE);
    do_op(0, 2'b10, 32'hFFFFFFFF, 32'h2, -1, res);     chk("multu_ff_2", res, 64'h00000001_FFFFFFFE);
    do_op(0, 2'b11, 32'h80000000, 32'h80000000, -1, res); chk("mult_mn_mn", res, 64'h40000000_00000000);

    // Annul in the middle of CALC: nothing completes and the old result stays.
    do_op(0, 2'b00, 32'd100, 32'd7, 10, res);          chk("annul_keeps_result", res, 64'h40000000_00000000);
    chk("annul_busy_low", 64'(b32.busy_o), 64'h0);
    do_op(0, 2'b00, 32'd100, 32'd7, -1, res);          chk("after_annul", res, 64'h00000002_0000000E);

    // Reset in the middle of an operation.
    c0 = cyc;
    r.u = 0; r.from = c0 + 1; r.to = c0 + 5; r.rdy = -1; r.res = 64'h0; r.dbz = 1'b0;
    q.push_back(r);
    drive(0, 1'b1, 1'b0, 2'b00, 32'd100, 32'd7);
    @(posedge clk); #1;
    drive(0, 1'b0, 1'b0, 2'b00, 32'd100, 32'd7);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    rst_cyc = c0 + 6;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_busy", 64'(b32.busy_o), 64'h0);
    chk("midrst_ready", 64'(b32.ready_o), 64'h0);
    chk("midrst_result", b32.result_o, 64'h0);
    chk("midrst_dbz", 64'(b32.div_by_zero_o), 64'h0);
    q.delete();

    // 8-bit instance.
    do_op(1, 2'b01, 32'h81, 32'h03, -1, res);          chk("div8_81_3", res, 64'h0000_0000_0000_FFD6);

    // Start held high: back-to-back operations accepted in each IDLE cycle.
    c0 = cyc;
    model(8, 2'b01, 32'h81, 32'h03, er, ed);
    r.u = 1; r.from = c0 + 1;  r.to = c0 + 9;  r.rdy = c0 + 9;  r.res = er; r.dbz = ed;
    q.push_back(r);
    r.u = 1; r.from = c0 + 11; r.to = c0 + 19; r.rdy = c0 + 19; r.res = er; r.dbz = ed;
    q.push_back(r);
    drive(1, 1'b1, 1'b0, 2'b01, 32'h81, 32'h03);
    repeat (19) begin @(posedge clk); #1; end
    drive(1, 1'b0, 1'b0, 2'b01, 32'h81, 32'h03);
    @(posedge clk); #1;
    chk("b2b_done", 64'(q.size()), 64'h0);
    q.delete();

    // Randomized operations on both widths, sometimes with an annul pulse.
    for (int i = 0; i < 80; i++) begin
      u  = i % 2;
      w  = (u == 0) ? 32 : 8;
      op = 2'($urandom_range(0, 3));
      a  = pick(w);
      b  = pick(w);
      ab = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, w + 2)) : -1;
      do_op(u, op, a, b, ab, res);
    end

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
